chip_host_link: RTL and testbench

Host-side counterpart of the chip's memory interface. Feeds 32-bit instruction words onto MemReadBus from an instruction FIFO. Captures 64-bit MemWriteBus results into a result FIFO whenever MemWriteValid is asserted. Sequences power-command words by stalling issue until power_ack is returned. Sits between the test/host fabric and the chip top level, in the bench harness and in the FPGA prototype wrapper.

---
 rtl/chip_host_link.sv | 206 ++++++++++++++++++++
 tb/tb_chip_host_link.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_host_link.sv
// chip_host_link: host-side memory interface shim for the chip.
// Queues host instruction words and issues them one per cycle on MemReadBus,
// holds issue after a power-controller command until power_ack rises (or a
// timeout expires), and captures MemWriteBus results into a first-word
// fall-through result FIFO.
module chip_host_link #(
    parameter int          IFIFO_DEPTH = 8,
    parameter int          RFIFO_DEPTH = 8,
    parameter logic [3:0]  PWR_PREFIX  = 4'hF,
    parameter int          ACK_TIMEOUT = 64,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst_data,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic        issue_enable,
    output logic [31:0] MemReadBus,
    input  logic [63:0] MemWriteBus,
    input  logic        MemWriteValid,
    input  logic        power_ack,
    input  logic        MemOverflow,
    output logic [63:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        pwr_wait,
    output logic        pwr_timeout,
    output logic        res_overflow,
    output logic        mem_ovfl_seen,
    input  logic        clear_status,
    output logic [15:0] issued_count
);

    localparam int IAW = $clog2(IFIFO_DEPTH);
    localparam int RAW = $clog2(RFIFO_DEPTH);
    localparam int TW  = $clog2(ACK_TIMEOUT) + 1;

    localparam logic [IAW:0]  IPTR_ONE = (IAW+1)'(1);
    localparam logic [RAW:0]  RPTR_ONE = (RAW+1)'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_HALT     = 2'd1;
    localparam logic [1:0] ST_PWR_WAIT = 2'd2;

    logic [1:0]    state;
    logic [TW-1:0] tmo_cnt;
    logic          ack_d;
    logic          ack_rise;
    logic          tmo_fire;

    // Instruction FIFO storage and pointers (extra MSB is the wrap bit)
    logic [31:0]  ififo_mem [IFIFO_DEPTH];
    logic [IAW:0] iwr_ptr;
    logic [IAW:0] ird_ptr;
    logic         ifull;
    logic         iempty;
    logic         ipush;
    logic         ipop;
    logic [31:0]  ihead;

    // Result FIFO storage and pointers
    logic [63:0]  rfifo_mem [RFIFO_DEPTH];
    logic [RAW:0] rwr_ptr;
    logic [RAW:0] rrd_ptr;
    logic         rfull;
    logic         rempty;
    logic         rpush;
    logic         rpop;
    logic         rdrop;

    assign iempty = (iwr_ptr == ird_ptr);
    assign ifull  = (iwr_ptr[IAW] != ird_ptr[IAW]) &&
                    (iwr_ptr[IAW-1:0] == ird_ptr[IAW-1:0]);
    assign ihead  = ififo_mem[ird_ptr[IAW-1:0]];

    assign inst_ready = ~ifull;
    assign ipush      = inst_valid & ~ifull;
    // Only RUN pops, and only while the host allows issue.
    assign ipop       = (state == ST_RUN) & issue_enable & ~iempty;

    assign rempty = (rwr_ptr == rrd_ptr);
    assign rfull  = (rwr_ptr[RAW] != rrd_ptr[RAW]) &&
                    (rwr_ptr[RAW-1:0] == rrd_ptr[RAW-1:0]);

    assign res_valid = ~rempty;
    assign res_data  = rfifo_mem[rrd_ptr[RAW-1:0]];
    assign rpop      = res_valid & res_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign rpush     = MemWriteValid & (~rfull | rpop);
    assign rdrop     = MemWriteValid & rfull & ~rpop;

    // Only the rising edge of the level-type acknowledge releases PWR_WAIT;
    // an ack arriving on the expiry cycle wins over the timeout.
    assign ack_rise = power_ack & ~ack_d;
    assign tmo_fire = (state == ST_PWR_WAIT) & ~ack_rise & (tmo_cnt == TMO_LAST);
    assign pwr_wait = (state == ST_PWR_WAIT);

    // Instruction FIFO write port (storage is data, not reset)
    always_ff @(posedge clock) begin
        if (ipush) begin
            ififo_mem[iwr_ptr[IAW-1:0]] <= inst_data;
        end
    end

    // Instruction FIFO pointers
    always_ff @(posedge clock) begin
        if (!reset) begin
            iwr_ptr <= '0;
            ird_ptr <= '0;
        end else begin
            if (ipush) iwr_ptr <= iwr_ptr + IPTR_ONE;
            if (ipop)  ird_ptr <= ird_ptr + IPTR_ONE;
        end
    end

    // Registered copy of power_ack for edge detection
    always_ff @(posedge clock) begin
        if (!reset) begin
            ack_d <= 1'b0;
        end else begin
            ack_d <= power_ack;
        end
    end

    // Issue FSM: drives MemReadBus, counts issued words, runs the ack timeout
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ST_RUN;
            MemReadBus   <= NOP_WORD;
            issued_count <= 16'd0;
            tmo_cnt      <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ipop) begin
                        MemReadBus   <= ihead;
                        issued_count <= issued_count + 16'd1;
                        if (ihead[31:28] == PWR_PREFIX) begin
                            state <= ST_PWR_WAIT;
                        end
                    end else begin
                        MemReadBus <= NOP_WORD;
                    end
                    if (!issue_enable) begin
                        state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    MemReadBus <= NOP_WORD;
                    if (issue_enable) begin
                        state <= ST_RUN;
                    end
                end
                ST_PWR_WAIT: begin
                    MemReadBus <= NOP_WORD;
                    if (ack_rise || tmo_fire) begin
                        state   <= ST_RUN;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    MemReadBus <= NOP_WORD;
                    tmo_cnt    <= '0;
                end
            endcase
        end
    end

    // Result FIFO write port (storage is data, not reset)
    always_ff @(posedge clock) begin
        if (rpush) begin
            rfifo_mem[rwr_ptr[RAW-1:0]] <= MemWriteBus;
        end
    end

    // Result FIFO pointers
    always_ff @(posedge clock) begin
        if (!reset) begin
            rwr_ptr <= '0;
            rrd_ptr <= '0;
        end else begin
            if (rpush) rwr_ptr <= rwr_ptr + RPTR_ONE;
            if (rpop)  rrd_ptr <= rrd_ptr + RPTR_ONE;
        end
    end

    // Sticky status flags; a set event in the clear cycle keeps the flag set
    always_ff @(posedge clock) begin
        if (!reset) begin
            pwr_timeout   <= 1'b0;
            res_overflow  <= 1'b0;
            mem_ovfl_seen <= 1'b0;
        end else begin
            pwr_timeout   <= tmo_fire    | (pwr_timeout   & ~clear_status);
            res_overflow  <= rdrop       | (res_overflow  & ~clear_status);
            mem_ovfl_seen <= MemOverflow | (mem_ovfl_seen & ~clear_status);
        end
    end

endmodule

// File: tb/tb_chip_host_link.sv
// Self-checking bench for chip_host_link: directed stimulus with scoreboard
// queues for issued instruction words and popped result words.
module tb_chip_host_link;

    localparam int          ID  = 8;
    localparam int          RD  = 8;
    localparam int          TMO = 64;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inst_data = '0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic        issue_enable = 1'b0;
    logic [31:0] MemReadBus;
    logic [63:0] MemWriteBus = '0;
    logic        MemWriteValid = 1'b0;
    logic        power_ack = 1'b0;
    logic        MemOverflow = 1'b0;
    logic [63:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        pwr_wait;
    logic        pwr_timeout;
    logic        res_overflow;
    logic        mem_ovfl_seen;
    logic        clear_status = 1'b0;
    logic [15:0] issued_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_issued = 0;
    int cyc;

    logic [31:0] iq[$];
    logic [63:0] rq[$];

    chip_host_link #(
        .IFIFO_DEPTH(ID),
        .RFIFO_DEPTH(RD),
        .PWR_PREFIX (4'hF),
        .ACK_TIMEOUT(TMO),
        .NOP_WORD   (NOP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .inst_data    (inst_data),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .issue_enable (issue_enable),
        .MemReadBus   (MemReadBus),
        .MemWriteBus  (MemWriteBus),
        .MemWriteValid(MemWriteValid),
        .power_ack    (power_ack),
        .MemOverflow  (MemOverflow),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .pwr_wait     (pwr_wait),
        .pwr_timeout  (pwr_timeout),
        .res_overflow (res_overflow),
        .mem_ovfl_seen(mem_ovfl_seen),
        .clear_status (clear_status),
        .issued_count (issued_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        inst_data  = w;
        inst_valid = 1'b1;
        if (inst_ready) begin
            iq.push_back(w);
            exp_issued++;
        end
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic res_push(input logic [63:0] d);
        MemWriteBus   = d;
        MemWriteValid = 1'b1;
        if (rq.size() < RD || (res_ready && rq.size() > 0)) begin
            rq.push_back(d);
        end
        tick();
        MemWriteValid = 1'b0;
    endtask

    // Count consecutive pwr_wait cycles starting from the current cycle.
    task automatic measure_wait(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (pwr_wait) n++;
            else if (n > 0) break;
            tick();
        end
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (reset) begin
            if (MemReadBus !== NOP) begin
                if (iq.size() == 0) chk("issue_spurious", {32'b0, MemReadBus}, {32'b0, NOP});
                else                chk("issue_order", {32'b0, MemReadBus}, {32'b0, iq.pop_front()});
            end
            if (res_valid && res_ready) begin
                if (rq.size() == 0) chk("res_spurious", res_data, 64'hDEAD);
                else                chk("res_order", res_data, rq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        issue_enable = 1'b1;
        repeat (3) tick();
        chk("rst_inst_ready", inst_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_memread", MemReadBus, NOP);
        chk("rst_pwr_wait", pwr_wait, 0);
        chk("rst_flags", {pwr_timeout, res_overflow, mem_ovfl_seen}, 0);
        chk("rst_count", issued_count, 0);
        reset = 1'b1;
        tick();

        // Back-to-back issue
        push_word(32'h1000_0001);
        push_word(32'h1000_0002);
        push_word(32'h1000_0003);
        repeat (4) tick();
        chk("t1_drain", iq.size(), 0);
        chk("t1_count", issued_count, 3);
        chk("t1_nop", MemReadBus, NOP);

        // Power command, no ack: timeout
        push_word(32'hF000_0010);
        push_word(32'h1000_0020);
        measure_wait(cyc);
        chk("t2_wait_cycles", cyc, TMO);
        chk("t2_timeout", pwr_timeout, 1);
        tick();
        chk("t2_next_issue", MemReadBus, 32'h1000_0020);
        pulse_clear();
        chk("t2_clear", pwr_timeout, 0);

        // Power command released by ack rising 5 cycles in
        push_word(32'hF000_0030);
        push_word(32'h1000_0040);
        repeat (4) tick();
        power_ack = 1'b1;
        tick();
        chk("t3_ack_exit", pwr_wait, 0);
        tick();
        chk("t3_issue", MemReadBus, 32'h1000_0040);
        chk("t3_no_timeout", pwr_timeout, 0);
        // Ack held high does not release a later power command
        push_word(32'hF000_0050);
        push_word(32'h1000_0060);
        measure_wait(cyc);
        chk("t3_level_wait", cyc, TMO);
        chk("t3_level_timeout", pwr_timeout, 1);
        power_ack = 1'b0;
        repeat (2) tick();
        chk("t3_drain", iq.size(), 0);
        pulse_clear();

        // Result FIFO overflow and in-order drain
        res_ready = 1'b0;
        for (int i = 0; i < 9; i++) res_push(64'hA + 64'(i));
        chk("t4_overflow", res_overflow, 1);
        chk("t4_valid", res_valid, 1);
        chk("t4_head", res_data, 64'hA);
        pulse_clear();
        chk("t4_clear", res_overflow, 0);
        res_ready = 1'b1;
        res_push(64'h100);
        chk("t4_full_pushpop", res_overflow, 0);
        for (int i = 0; i < 20; i++) begin
            if (!res_valid) break;
            tick();
        end
        chk("t4_drained", rq.size(), 0);
        chk("t4_empty", res_valid, 0);
        res_ready = 1'b0;
        res_push(64'h200);
        chk("t4_fwft_valid", res_valid, 1);
        chk("t4_fwft_data", res_data, 64'h200);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t4_pop_one", rq.size(), 0);

        // Memory overflow sticky, set beats clear
        MemOverflow = 1'b1;
        tick();
        MemOverflow = 1'b0;
        chk("t5_ovfl_set", mem_ovfl_seen, 1);
        MemOverflow  = 1'b1;
        clear_status = 1'b1;
        tick();
        MemOverflow  = 1'b0;
        clear_status = 1'b0;
        chk("t5_set_wins", mem_ovfl_seen, 1);
        pulse_clear();
        chk("t5_ovfl_clear", mem_ovfl_seen, 0);

        // Fill while halted, then resume with a mid-stream halt
        issue_enable = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < ID; i++) push_word(32'h2000_0000 + 32'(i));
        chk("t6_full", inst_ready, 0);
        push_word(32'h2000_00FF);
        chk("t6_queued", iq.size(), ID);
        issue_enable = 1'b1;
        repeat (3) tick();
        issue_enable = 1'b0;
        repeat (3) tick();
        chk("t6_halt_nop", MemReadBus, NOP);
        chk("t6_halt_pending", iq.size(), ID - 2);
        issue_enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (iq.size() == 0) break;
            tick();
        end
        chk("t6_drained", iq.size(), 0);
        tick();
        chk("t6_count", issued_count, 16'(exp_issued));

        // Reset mid-stream while in PWR_WAIT with queued work and flags set
        issue_enable = 1'b0;
        repeat (2) tick();
        push_word(32'hF000_0070);
        push_word(32'h3000_0001);
        push_word(32'h3000_0002);
        res_push(64'h300);
        MemOverflow = 1'b1;
        tick();
        MemOverflow = 1'b0;
        issue_enable = 1'b1;
        repeat (3) tick();
        chk("t7_in_wait", pwr_wait, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        iq.delete();
        rq.delete();
        exp_issued = 0;
        chk("t7_inst_ready", inst_ready, 1);
        chk("t7_res_valid", res_valid, 0);
        chk("t7_memread", MemReadBus, NOP);
        chk("t7_pwr_wait", pwr_wait, 0);
        chk("t7_flags", {pwr_timeout, res_overflow, mem_ovfl_seen}, 0);
        chk("t7_count", issued_count, 0);
        push_word(32'h3000_0010);
        repeat (3) tick();
        chk("t7_run_issue", iq.size(), 0);
        chk("t7_count_after", issued_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
